// File: rtl/seq_alu_core.sv
// Multi-cycle ALU: single-cycle logic/arithmetic, iterative shifts (one bit per
// cycle) and shift-add multiply, with registered result, flags and done pulse.
module seq_alu_core #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf,
  output logic             err,
  output logic [1:0]       state_dbg
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;

  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_t;

  state_t state, state_d;

  // Handshake: an op is accepted on any rising edge where start=1 and busy=0;
  // start while busy is dropped, and each accepted op yields exactly one done.
  logic             accept;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] mcand_q, work_hi, work_lo;
  logic [SHW:0]     cnt;

  logic [SHW-1:0]   s_amt;
  logic [WIDTH:0]   add_full, sub_full, mul_sum;
  logic [WIDTH-1:0] sh_next, mul_hi_next, mul_lo_next;
  logic             sh_out;

  logic             cpl, wr_res;
  logic [WIDTH-1:0] res_d, hi_d;
  logic             z_d, c_d, n_d, o_d, err_d;

  assign accept    = start && (state == S_IDLE);
  assign s_amt     = b[SHW-1:0];
  assign add_full  = {1'b0, a} + {1'b0, b};
  assign sub_full  = {1'b0, a} - {1'b0, b};
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_comb begin
    sh_next = {1'b0, work_lo[WIDTH-1:1]};
    sh_out  = work_lo[0];
    case (op_q)
      OP_SHL:  begin sh_next = {work_lo[WIDTH-2:0], 1'b0}; sh_out = work_lo[WIDTH-1]; end
      OP_SRA:  sh_next = {work_lo[WIDTH-1], work_lo[WIDTH-1:1]};
      default: ;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand, then shift the
  // {hi, lo} pair right so consumed multiplier bits fall out of work_lo.
  assign mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mcand_q} : '0);
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], work_lo[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    cpl     = 1'b0;
    wr_res  = 1'b0;
    res_d   = '0;
    hi_d    = '0;
    c_d     = 1'b0;
    o_d     = 1'b0;
    err_d   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (opcode)
            OP_ADD: begin
              cpl = 1'b1; wr_res = 1'b1;
              res_d = add_full[WIDTH-1:0];
              c_d   = add_full[WIDTH];
              o_d   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
              cpl = 1'b1; wr_res = (opcode == OP_SUB);
              res_d = sub_full[WIDTH-1:0];
              c_d   = sub_full[WIDTH];
              o_d   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  begin cpl = 1'b1; wr_res = 1'b1; res_d = a & b; end
            OP_OR:   begin cpl = 1'b1; wr_res = 1'b1; res_d = a | b; end
            OP_XOR:  begin cpl = 1'b1; wr_res = 1'b1; res_d = a ^ b; end
            OP_NOT:  begin cpl = 1'b1; wr_res = 1'b1; res_d = ~a; end
            OP_PASS: begin cpl = 1'b1; wr_res = 1'b1; res_d = b; end
            OP_SHL, OP_SHR, OP_SRA: begin
              if (s_amt == '0) begin
                cpl = 1'b1; wr_res = 1'b1; res_d = a;
              end else begin
                state_d = S_SHIFT;
              end
            end
            OP_MUL:  state_d = S_MUL;
            default: begin cpl = 1'b1; wr_res = 1'b1; err_d = 1'b1; end
          endcase
        end
      end
      S_SHIFT: begin
        if (cnt == CNT_ONE) begin
          state_d = S_IDLE;
          cpl = 1'b1; wr_res = 1'b1;
          res_d = sh_next;
          c_d   = sh_out;
        end
      end
      S_MUL: begin
        if (cnt == CNT_ONE) begin
          state_d = S_IDLE;
          cpl = 1'b1; wr_res = 1'b1;
          res_d = mul_lo_next;
          hi_d  = mul_hi_next;
          c_d   = |mul_hi_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // MUL flags describe the full double-width product.
    if (state == S_MUL) begin
      z_d = ~|{hi_d, res_d};
      n_d = hi_d[WIDTH-1];
    end else begin
      z_d = ~|res_d;
      n_d = res_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      mcand_q <= '0;
      work_hi <= '0;
      work_lo <= '0;
      cnt     <= '0;
    end else if (accept) begin
      op_q    <= opcode;
      mcand_q <= a;
      work_hi <= '0;
      work_lo <= (opcode == OP_MUL) ? b : a;
      cnt     <= (opcode == OP_MUL) ? CNT_MUL : {1'b0, s_amt};
    end else if (state == S_SHIFT) begin
      work_lo <= sh_next;
      cnt     <= cnt - CNT_ONE;
    end else if (state == S_MUL) begin
      work_hi <= mul_hi_next;
      work_lo <= mul_lo_next;
      cnt     <= cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= cpl;
      if (cpl) begin
        zero  <= z_d;
        carry <= c_d;
        neg   <= n_d;
        ovf   <= o_d;
        err   <= err_d;
        if (wr_res) begin
          result    <= res_d;
          result_hi <= hi_d;
        end
      end
    end
  end

endmodule
